memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameters: none; all widths come from cpu_types_pkg (word_t = 32, regbits_t = 5).
REQ-002 CLK  in  1  rising-edge clock.
REQ-003 nRST  in  1  asynchronous active-low reset.
REQ-004 memen  in  1  hazard-unit enable; EX/MEM latch loads when memen=1 and mem_stall=0.
REQ-005 flush  in  1  squash the instruction entering the latch.
REQ-006 instru_mem  in  32  instruction word from execute; instru_mem_next  out  32  registered copy toward writeback.
REQ-007 nPC, ALUOut, dmemstore  in  32 each  execute results; dREN, dWEN, regWr, halt, lui  in  1 each; regSel  in  2; regDst  in  5.
REQ-008 dmemREN, dmemWEN  out  1  data-memory request; dmemaddr, dmemstore_o  out  32  address and store data.
REQ-009 dhit  in  1  memory completion; dmemload  in  32  load data, valid when dhit=1.
REQ-010 mem_stall  out  1  pipeline freeze request.
REQ-011 regWr_next, halt_next, lui_next  out  1; regSel_next  out  2; regDst_next  out  5; nPC_next, ALUOut_next, dmemload_next  out  32: MEM/WB register.
REQ-012 fwd_valid  out  1, fwd_reg  out  5, fwd_data  out  32: forwarding tap (see Configuration).

Function
REQ-013 Two register banks: the EX/MEM latch (inputs of REQ-007) and the MEM/WB register (REQ-011).
REQ-014 FSM states: IDLE, ACCESS. IDLE->ACCESS when the latch is loaded with dREN|dWEN=1 and halt=0; ACCESS->IDLE on dhit=1.
REQ-015 dmemREN/dmemWEN equal the latched dREN/dWEN only in ACCESS, else 0; dmemaddr = latched ALUOut; dmemstore_o = latched dmemstore.
REQ-016 mem_stall = (state==ACCESS) & ~dhit, combinational.
REQ-017 MEM/WB register loads from the EX/MEM latch on every edge where mem_stall=0; dmemload_next captures dmemload when dhit=1, else holds.
REQ-018 Latency: non-memory instruction reaches MEM/WB one cycle after latching; memory instruction reaches it on the edge where dhit=1 (minimum one cycle).
REQ-019 flush with mem_stall=0 loads a bubble (all control fields 0, instru 0) into the EX/MEM latch, priority over memen.
REQ-020 flush with mem_stall=1 sets a pending-flush flop; the access completes, then the bubble is loaded on the dhit edge; pending flag clears there.
REQ-021 memen=0 with mem_stall=0: EX/MEM latch holds; MEM/WB register receives a bubble (regWr_next=0) to prevent double writeback.
REQ-022 Latched halt suppresses memory requests; halt_next is sticky at 1 until reset.
REQ-023 dhit in IDLE is ignored.

Reset
REQ-024 nRST=0 forces state=IDLE, pending-flush=0, every latch field and every output register to 0, all outputs 0, immediately and regardless of CLK.
REQ-025 Reset during ACCESS abandons the request; dmemREN/dmemWEN drop asynchronously.

Configuration
REQ-026 Macro MEM_FWD_EN defined: fwd_valid = regWr_next & (regDst_next!=0); fwd_reg = regDst_next; fwd_data = dmemload_next when regSel_next selects memory, else ALUOut_next.
REQ-027 Macro MEM_FWD_EN undefined: ports remain present, tied to 0.

Structure
REQ-028 word_t, regbits_t and the regSel encoding constants live in cpu_types_pkg; the FSM state enum is local.
REQ-029 Ports grouped in a memory_if interface with modports mem (this block), hu (hazard unit), wb.
REQ-030 No sub-module; FSM and registers are inline.

Verification
REQ-031 ALU op, ALUOut=0x0000_0010, regWr=1, memen=1 -> next cycle ALUOut_next=0x10, regWr_next=1, mem_stall never 1.
REQ-032 Load to 0x0000_0040, dhit after 3 cycles with dmemload=0xDEAD_BEEF -> mem_stall=1 for 3 cycles, dmemREN=1 throughout, dmemload_next=0xDEADBEEF on the dhit edge.
REQ-033 Store, dmemstore=0x1234_5678, dhit same cycle -> dmemWEN=1 for one cycle, dmemstore_o=0x12345678, mem_stall=0.
REQ-034 flush asserted during a stalled load -> load completes, next latch content is a bubble, regWr_next=0 on the following cycle.
REQ-035 nRST pulsed mid-ACCESS -> dmemREN=0 immediately, all outputs 0, state IDLE.
REQ-036 MEM_FWD_EN defined, load to r5 completes -> fwd_valid=1, fwd_reg=5, fwd_data=load data; undefined -> all three 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU datapath types and writeback-select encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    localparam int WORD_W    = 32;
    localparam int REGBITS_W = 5;

    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [REGBITS_W-1:0] regbits_t;
    typedef logic [1:0]           regsel_t;

    // Writeback source select carried alongside each instruction
    localparam regsel_t c_REGSEL_ALU = 2'd0;
    localparam regsel_t c_REGSEL_MEM = 2'd1;
    localparam regsel_t c_REGSEL_NPC = 2'd2;
    localparam regsel_t c_REGSEL_LUI = 2'd3;

endpackage
`default_nettype wire

// File: rtl/memory_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_if
// Description : Signal bundle around the memory stage: execute results in,
//               data-memory request/response, hazard control, MEM/WB outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface memory_if;
    import cpu_types_pkg::*;

    // hazard control
    logic     memen;
    logic     flush;
    logic     mem_stall;

    // execute results
    word_t    instru_mem;
    word_t    nPC;
    word_t    ALUOut;
    word_t    dmemstore;
    logic     dREN;
    logic     dWEN;
    logic     regWr;
    logic     halt;
    logic     lui;
    regsel_t  regSel;
    regbits_t regDst;

    // data memory
    logic     dmemREN;
    logic     dmemWEN;
    word_t    dmemaddr;
    word_t    dmemstore_o;
    logic     dhit;
    word_t    dmemload;

    // MEM/WB register
    word_t    instru_mem_next;
    logic     regWr_next;
    logic     halt_next;
    logic     lui_next;
    regsel_t  regSel_next;
    regbits_t regDst_next;
    word_t    nPC_next;
    word_t    ALUOut_next;
    word_t    dmemload_next;

    // forwarding tap
    logic     fwd_valid;
    regbits_t fwd_reg;
    word_t    fwd_data;

    modport mem (
        input  memen, flush,
        input  instru_mem, nPC, ALUOut, dmemstore,
        input  dREN, dWEN, regWr, halt, lui, regSel, regDst,
        input  dhit, dmemload,
        output mem_stall,
        output dmemREN, dmemWEN, dmemaddr, dmemstore_o,
        output instru_mem_next, regWr_next, halt_next, lui_next,
        output regSel_next, regDst_next, nPC_next, ALUOut_next, dmemload_next,
        output fwd_valid, fwd_reg, fwd_data
    );

    modport hu (
        output memen, flush,
        input  mem_stall,
        input  fwd_valid, fwd_reg, fwd_data
    );

    modport wb (
        input  instru_mem_next, regWr_next, halt_next, lui_next,
        input  regSel_next, regDst_next, nPC_next, ALUOut_next, dmemload_next
    );

endinterface
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage
// Description : Pipeline memory stage: EX/MEM latch, data-memory access FSM,
//               MEM/WB register. Define MEM_FWD_EN to drive the forwarding tap.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_stage
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     nRST,
    memory_if.mem    mif
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef struct packed {
        word_t    instru;
        word_t    npc;
        word_t    alu;
        word_t    store;
        logic     dren;
        logic     dwen;
        logic     regwr;
        logic     halt;
        logic     lui;
        regsel_t  regsel;
        regbits_t regdst;
    } exmem_t;

    localparam exmem_t c_BUBBLE = '0;

    state_t   r_state;
    exmem_t   r_exm;
    logic     r_flush_pend;

    word_t    r_instru_wb;
    word_t    r_npc_wb;
    word_t    r_alu_wb;
    word_t    r_dload_wb;
    logic     r_regwr_wb;
    logic     r_halt_wb;
    logic     r_lui_wb;
    regsel_t  r_regsel_wb;
    regbits_t r_regdst_wb;

    exmem_t   w_in;
    logic     w_stall;
    logic     w_kill;
    logic     w_latch_load;
    logic     w_start_mem;
    logic     w_hit_access;
    logic     w_req_ok;

    assign w_in = '{
        instru : mif.instru_mem,
        npc    : mif.nPC,
        alu    : mif.ALUOut,
        store  : mif.dmemstore,
        dren   : mif.dREN,
        dwen   : mif.dWEN,
        regwr  : mif.regWr,
        halt   : mif.halt,
        lui    : mif.lui,
        regsel : mif.regSel,
        regdst : mif.regDst
    };

    assign w_hit_access = (r_state == ACCESS) & mif.dhit;
    assign w_stall      = (r_state == ACCESS) & ~mif.dhit;

    // A flush seen during a stall is remembered and applied on the dhit edge
    assign w_kill       = mif.flush | r_flush_pend;
    assign w_latch_load = ~w_stall & (w_kill | mif.memen);
    assign w_start_mem  = w_latch_load & ~w_kill & (w_in.dren | w_in.dwen) & ~w_in.halt;

    // ---------------- EX/MEM latch ----------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_exm        <= c_BUBBLE;
            r_flush_pend <= 1'b0;
        end else begin
            if (w_latch_load) begin
                r_exm <= w_kill ? c_BUBBLE : w_in;
            end
            r_flush_pend <= w_stall & w_kill;
        end
    end

    // ---------------- access FSM ----------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_mem) begin
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // back-to-back accesses stay in ACCESS across the dhit edge
                    if (mif.dhit) begin
                        r_state <= w_start_mem ? ACCESS : IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // ---------------- MEM/WB register ----------------
    // Advances together with the EX/MEM latch; while memen holds the latch,
    // writeback sees a bubble so the held instruction is not retired twice.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_instru_wb <= '0;
            r_npc_wb    <= '0;
            r_alu_wb    <= '0;
            r_regwr_wb  <= 1'b0;
            r_halt_wb   <= 1'b0;
            r_lui_wb    <= 1'b0;
            r_regsel_wb <= '0;
            r_regdst_wb <= '0;
        end else if (!w_stall) begin
            if (mif.memen) begin
                r_instru_wb <= r_exm.instru;
                r_npc_wb    <= r_exm.npc;
                r_alu_wb    <= r_exm.alu;
                r_regwr_wb  <= r_exm.regwr;
                r_lui_wb    <= r_exm.lui;
                r_regsel_wb <= r_exm.regsel;
                r_regdst_wb <= r_exm.regdst;
                r_halt_wb   <= r_halt_wb | r_exm.halt;
            end else begin
                r_instru_wb <= '0;
                r_npc_wb    <= '0;
                r_alu_wb    <= '0;
                r_regwr_wb  <= 1'b0;
                r_lui_wb    <= 1'b0;
                r_regsel_wb <= '0;
                r_regdst_wb <= '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_dload_wb <= '0;
        end else if (w_hit_access) begin
            r_dload_wb <= mif.dmemload;
        end
    end

    // ---------------- outputs ----------------
    assign w_req_ok        = (r_state == ACCESS) & ~r_exm.halt;
    assign mif.dmemREN     = w_req_ok & r_exm.dren;
    assign mif.dmemWEN     = w_req_ok & r_exm.dwen;
    assign mif.dmemaddr    = r_exm.alu;
    assign mif.dmemstore_o = r_exm.store;
    assign mif.mem_stall   = w_stall;

    assign mif.instru_mem_next = r_instru_wb;
    assign mif.regWr_next      = r_regwr_wb;
    assign mif.halt_next       = r_halt_wb;
    assign mif.lui_next        = r_lui_wb;
    assign mif.regSel_next     = r_regsel_wb;
    assign mif.regDst_next     = r_regdst_wb;
    assign mif.nPC_next        = r_npc_wb;
    assign mif.ALUOut_next     = r_alu_wb;
    assign mif.dmemload_next   = r_dload_wb;

`ifdef MEM_FWD_EN
    assign mif.fwd_valid = r_regwr_wb & (r_regdst_wb != '0);
    assign mif.fwd_reg   = r_regdst_wb;
    assign mif.fwd_data  = (r_regsel_wb == c_REGSEL_MEM) ? r_dload_wb : r_alu_wb;
`else
    assign mif.fwd_valid = 1'b0;
    assign mif.fwd_reg   = '0;
    assign mif.fwd_data  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_stage
// Description : Self-checking bench for memory_stage with writeback scoreboard
//               and an autonomous data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_stage;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    memory_if mif();

    memory_stage dut (
        .CLK  (CLK),
        .nRST (nRST),
        .mif  (mif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        word_t       instru;
        word_t       npc;
        word_t       alu;
        word_t       store;
        logic        dren;
        logic        dwen;
        logic        regwr;
        logic        halt;
        logic [1:0]  regsel;
        logic [4:0]  regdst;
        logic        is_load;
        word_t       load;
    } txn_t;

    txn_t sb[$];
    txn_t mt;
    txn_t nop;

    function automatic txn_t mk(input word_t instru, input word_t alu, input word_t store,
                                input logic dren, input logic dwen, input logic regwr,
                                input logic halt, input logic [1:0] regsel, input logic [4:0] regdst);
        txn_t t;
        t.instru  = instru;
        t.npc     = (instru == 32'h0) ? 32'h0 : instru + 32'h4;
        t.alu     = alu;
        t.store   = store;
        t.dren    = dren;
        t.dwen    = dwen;
        t.regwr   = regwr;
        t.halt    = halt;
        t.regsel  = regsel;
        t.regdst  = regdst;
        t.is_load = dren & ~halt;
        t.load    = 32'h0;
        return t;
    endfunction

    task automatic drive(input txn_t t);
        mif.instru_mem = t.instru;
        mif.nPC        = t.npc;
        mif.ALUOut     = t.alu;
        mif.dmemstore  = t.store;
        mif.dREN       = t.dren;
        mif.dWEN       = t.dwen;
        mif.regWr      = t.regwr;
        mif.halt       = t.halt;
        mif.lui        = 1'b0;
        mif.regSel     = t.regsel;
        mif.regDst     = t.regdst;
        mif.memen      = 1'b1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // data-memory responder: answers lat cycles after a request appears
    int    lat      = 0;
    word_t load_val = 32'h0;
    bit    spurious = 1'b0;
    int    rsp_cnt  = 0;

    initial begin
        mif.dhit     = 1'b0;
        mif.dmemload = 32'h0;
        forever begin
            @(posedge CLK);
            #2;
            if (mif.dhit) begin
                mif.dhit = 1'b0;
                rsp_cnt  = 0;
            end
            if (mif.dmemREN | mif.dmemWEN) begin
                if (rsp_cnt >= lat) begin
                    mif.dhit     = 1'b1;
                    mif.dmemload = load_val;
                end else begin
                    rsp_cnt++;
                end
            end else begin
                rsp_cnt = 0;
                if (spurious) begin
                    mif.dhit     = 1'b1;
                    mif.dmemload = 32'hBAD0_0BAD;
                end
            end
        end
    end

    // writeback monitor: each new non-bubble instruction retires one entry
    word_t last_instru = 32'h0;
    always @(negedge CLK) begin
        if (nRST && mif.instru_mem_next != 32'h0 && mif.instru_mem_next != last_instru) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", mif.instru_mem_next, 32'h0);
            end else begin
                mt = sb.pop_front();
                check("wb_instru", mif.instru_mem_next, mt.instru);
                check("wb_npc", mif.nPC_next, mt.npc);
                check("wb_aluout", mif.ALUOut_next, mt.alu);
                check("wb_regwr", 32'(mif.regWr_next), 32'(mt.regwr));
                check("wb_regdst", 32'(mif.regDst_next), 32'(mt.regdst));
                check("wb_regsel", 32'(mif.regSel_next), 32'(mt.regsel));
                if (mt.is_load) check("wb_dload", mif.dmemload_next, mt.load);
            end
        end
        last_instru = mif.instru_mem_next;
    end

    task automatic wait_access(input logic ren, input logic wen, output int stalls);
        bit done = 1'b0;
        stalls = 0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge CLK);
            check("req_ren", 32'(mif.dmemREN), 32'(ren));
            check("req_wen", 32'(mif.dmemWEN), 32'(wen));
            if (mif.dhit) done = 1'b1;
            else if (mif.mem_stall) stalls++;
        end
        if (!done) check("access_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        txn_t a, b, c, l, s, f, g, x, h, r, fw;
        int   st;

        nop       = mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, c_REGSEL_ALU, 5'd0);
        nRST      = 1'b0;
        mif.flush = 1'b0;
        drive(nop);
        #1;
        check("rst_ren", 32'(mif.dmemREN), 32'h0);
        check("rst_stall", 32'(mif.mem_stall), 32'h0);
        check("rst_regwr", 32'(mif.regWr_next), 32'h0);
        check("rst_addr", mif.dmemaddr, 32'h0);
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        tick();

        // ALU op: one-cycle latency to MEM/WB, no stall
        a = mk(32'h0000_0100, 32'h0000_0010, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, c_REGSEL_ALU, 5'd3);
        sb.push_back(a);
        drive(a);
        tick();
        drive(nop);
        @(negedge CLK);
        check("alu_stall0", 32'(mif.mem_stall), 32'h0);
        check("alu_not_yet", 32'(mif.regWr_next), 32'h0);
        @(negedge CLK);
        check("alu_out", mif.ALUOut_next, 32'h0000_0010);
        check("alu_regwr", 32'(mif.regWr_next), 32'h1);
        check("alu_stall1", 32'(mif.mem_stall), 32'h0);

        // memen=0: latch holds B, writeback gets a bubble, B retires later
        b = mk(32'h0000_0110, 32'h0000_0055, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, c_REGSEL_ALU, 5'd4);
        c = mk(32'h0000_0111, 32'h0000_0066, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, c_REGSEL_NPC, 5'd6);
        sb.push_back(b);
        sb.push_back(c);
        drive(b);
        tick();
        drive(c);
        mif.memen = 1'b0;
        tick();
        @(negedge CLK);
        check("hold_addr", mif.dmemaddr, 32'h0000_0055);
        check("hold_bubble", 32'(mif.regWr_next), 32'h0);
        mif.memen = 1'b1;
        tick();
        drive(nop);
        tick();

        // load with three stall cycles
        lat      = 3;
        load_val = 32'hDEAD_BEEF;
        l        = mk(32'h0000_0200, 32'h0000_0040, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, c_REGSEL_MEM, 5'd8);
        l.load   = 32'hDEAD_BEEF;
        sb.push_back(l);
        drive(l);
        tick();
        drive(nop);
        wait_access(1'b1, 1'b0, st);
        check("load_stalls", 32'(st), 32'd3);
        check("load_addr", mif.dmemaddr, 32'h0000_0040);
        tick();
        @(negedge CLK);
        check("load_dload", mif.dmemload_next, 32'hDEAD_BEEF);
        check("load_ren_drop", 32'(mif.dmemREN), 32'h0);

        // store answered in the same cycle
        lat      = 0;
        load_val = 32'h0;
        s        = mk(32'h0000_0210, 32'h0000_0044, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, c_REGSEL_ALU, 5'd0);
        sb.push_back(s);
        drive(s);
        tick();
        drive(nop);
        wait_access(1'b0, 1'b1, st);
        check("store_stalls", 32'(st), 32'd0);
        check("store_data", mif.dmemstore_o, 32'h1234_5678);
        check("store_stall_now", 32'(mif.mem_stall), 32'h0);
        tick();
        @(negedge CLK);
        check("store_wen_once", 32'(mif.dmemWEN), 32'h0);

        // flush during a stalled load: load retires, G is replaced by a bubble
        lat      = 2;
        load_val = 32'h5A5A_1234;
        f        = mk(32'h0000_0300, 32'h0000_0080, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, c_REGSEL_MEM, 5'd7);
        f.load   = 32'h5A5A_1234;
        g        = mk(32'h0000_0301, 32'h0000_0099, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, c_REGSEL_ALU, 5'd9);
        sb.push_back(f);
        drive(f);
        tick();
        drive(g);
        mif.flush = 1'b1;
        tick();
        mif.flush = 1'b0;
        wait_access(1'b1, 1'b0, st);
        check("flush_hold_addr", mif.dmemaddr, 32'h0000_0080);
        tick();
        drive(nop);
        @(negedge CLK);
        check("flush_bubble_addr", mif.dmemaddr, 32'h0);
        check("flush_wb_load", mif.instru_mem_next, 32'h0000_0300);
        tick();
        @(negedge CLK);
        check("flush_wb_regwr", 32'(mif.regWr_next), 32'h0);
        check("flush_wb_instru", mif.instru_mem_next, 32'h0);

        // flush without stall: X never enters the latch
        x = mk(32'h0000_0310, 32'h0000_0077, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, c_REGSEL_ALU, 5'd2);
        drive(x);
        mif.flush = 1'b1;
        tick();
        mif.flush = 1'b0;
        drive(nop);
        @(negedge CLK);
        check("flush_now_addr", mif.dmemaddr, 32'h0);
        tick();
        @(negedge CLK);
        check("flush_now_regwr", 32'(mif.regWr_next), 32'h0);

        // halt with a read request: no memory access, sticky halt_next
        h = mk(32'h0000_0400, 32'h0000_0090, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, c_REGSEL_ALU, 5'd0);
        sb.push_back(h);
        drive(h);
        tick();
        drive(nop);
        @(negedge CLK);
        check("halt_no_req", 32'(mif.dmemREN), 32'h0);
        check("halt_no_stall", 32'(mif.mem_stall), 32'h0);
        @(negedge CLK);
        check("halt_next", 32'(mif.halt_next), 32'h1);
        repeat (3) tick();
        @(negedge CLK);
        check("halt_sticky", 32'(mif.halt_next), 32'h1);

        // asynchronous reset in the middle of an access
        lat = 100;
        r   = mk(32'h0000_0500, 32'h0000_0060, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, c_REGSEL_MEM, 5'd10);
        drive(r);
        tick();
        drive(nop);
        @(negedge CLK);
        check("rst_pre_ren", 32'(mif.dmemREN), 32'h1);
        #2 nRST = 1'b0;
        #1;
        check("rst_mid_ren", 32'(mif.dmemREN), 32'h0);
        check("rst_mid_stall", 32'(mif.mem_stall), 32'h0);
        check("rst_mid_halt", 32'(mif.halt_next), 32'h0);
        check("rst_mid_addr", mif.dmemaddr, 32'h0);
        check("rst_mid_instru", mif.instru_mem_next, 32'h0);
        check("rst_mid_fwd", 32'(mif.fwd_valid), 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        lat  = 1;
        tick();
        @(negedge CLK);
        check("rst_idle_ren", 32'(mif.dmemREN), 32'h0);

        // load to r5 then forwarding tap
        load_val = 32'hCAFE_F00D;
        fw       = mk(32'h0000_0600, 32'h0000_0048, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, c_REGSEL_MEM, 5'd5);
        fw.load  = 32'hCAFE_F00D;
        sb.push_back(fw);
        drive(fw);
        tick();
        drive(nop);
        wait_access(1'b1, 1'b0, st);
        tick();
        @(negedge CLK);
`ifdef MEM_FWD_EN
        check("fwd_valid", 32'(mif.fwd_valid), 32'h1);
        check("fwd_reg", 32'(mif.fwd_reg), 32'd5);
        check("fwd_data", mif.fwd_data, 32'hCAFE_F00D);
`else
        check("fwd_valid", 32'(mif.fwd_valid), 32'h0);
        check("fwd_reg", 32'(mif.fwd_reg), 32'd0);
        check("fwd_data", mif.fwd_data, 32'h0);
`endif

        // dhit while idle must not disturb anything
        spurious = 1'b1;
        tick();
        @(negedge CLK);
        check("idle_hit_stall", 32'(mif.mem_stall), 32'h0);
        spurious = 1'b0;
        tick();
        @(negedge CLK);
        check("idle_hit_dload", mif.dmemload_next, 32'hCAFE_F00D);
        check("idle_hit_ren", 32'(mif.dmemREN), 32'h0);

        repeat (2) tick();
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
